reg_share_arbiter: RTL and testbench
====================================

# reg_share_arbiter

Round-robin arbiter and write sequencer that shares one DW-bit register, built on the team's asynchronous-reset D flip-flop style, between N_REQ requesters. It grants one requester per tenure and writes the owner's data into the shared register on every cycle the grant is used. An optional lock lets a requester keep the register for a bounded burst. It sits between several producer blocks and the single storage element they contend for.

## Interface
- N_REQ, 4, number of requesters (≥2)
- DW, 8, data width of the shared register
- MAX_HOLD, 4, maximum cycles in one locked tenure (≥1; 1 disables lock)

- clk  in  1  rising-edge clock
- rst  in  1  reset: one clock; asynchronous, active-high
- req  in  N_REQ  per-requester request, level
- lock  in  N_REQ  per-requester tenure-extend request, qualified by req
- wdata  in  N_REQ*DW  packed write data, requester i at [i*DW +: DW]
- gnt  out  N_REQ  registered one-hot grant, or all zero
- owner_id  out  clog2(N_REQ)  index of current owner, valid when busy
- busy  out  1  high while a tenure is active
- q  out  DW  shared register contents

## Operation
- States: IDLE (no owner) and OWN (one owner, gnt one-hot).
- IDLE: if any req, pick the winner by round robin from ptr upward with wrap, then go to OWN. Otherwise stay in IDLE.
- OWN, owner i, at each rising edge:
  - If req[i]=1: q ← wdata[i] (the write).
  - The tenure continues only if req[i]=1, lock[i]=1 and hold_cnt < MAX_HOLD-1. In that case hold_cnt increments.
  - Otherwise the tenure ends. ptr ← (i+1) mod N_REQ. At the same edge, re-arbitrate among the current req from the new ptr, with no idle bubble. If the new req is zero, go to IDLE.
- Because the search wraps, the releasing owner is considered last. A sole requester is regranted immediately, and hold_cnt resets to 0 for each new tenure.
- Owner drops req: no write at that edge, and the tenure ends.
- Unlocked tenure lasts exactly one cycle, with one write.
- Locked tenure lasts up to MAX_HOLD cycles, with up to MAX_HOLD writes.
- lock without req is ignored. lock of a non-owner has no effect.
- hold_cnt width is clog2(MAX_HOLD+1). ptr width is clog2(N_REQ). ptr wraps from N_REQ-1 to 0.
- q holds its value on every edge without a write.

## Timing
- Reset values, applied immediately on rst rise regardless of clk:
  - gnt = 0, busy = 0, owner_id = 0, q = 0
  - state = IDLE, ptr = 0, hold_cnt = 0
- Reset mid-tenure aborts it: no write, and the first arbitration after reset starts from requester 0.
- Grant latency: req sampled at edge t (state IDLE) gives gnt high during cycle t..t+1.
- Write latency: gnt[i]&req[i] at edge t+1 makes q = wdata[i] from edge t+1.
- gnt, owner_id and busy are register outputs and change only on clk edges or rst.
- Back-to-back tenures: gnt switches owner at a single edge and is never zero in between while any req is pending.
- Release and new request at the same edge: the new request is arbitrated at that edge.

## Structure
- Shared package holds:
  - state enum {IDLE, OWN}
  - defaults for N_REQ, DW, MAX_HOLD
  - a function for clog2-based widths
- Sub-module rr_pick: combinational round-robin picker. Inputs are req[N_REQ] and ptr. Outputs are a one-hot winner, its index, and any_req. The FSM, counters and q register live in reg_share_arbiter.

## Test plan
- Reset: hold gnt=0001 with lock=0001, then pulse rst between clock edges. gnt=0000, busy=0 and q=00 within the same cycle. After rst falls, req=1001 grants requester 0 first.
- Single requester: req=0001, lock=0, wdata0=A5 then 3C. gnt=0001 stays continuous from the cycle after the first sample. q=A5 then 3C on successive edges.
- Full contention: req=1111, lock=0, wdata0..3=11,22,33,44. gnt sequence is 0001, 0010, 0100, 1000, 0001. q sequence is 11, 22, 33, 44, 11, one per cycle.
- Lock bound: req=0011, lock=0001, MAX_HOLD=4. gnt=0001 for exactly 4 cycles, then 0010 for 1 cycle, then 0001 again.
- Owner drops mid-lock: requester 0 locked, wdata0=77 then 88. req0 falls in cycle 2 while wdata0=88. No write of 88, q stays 77. gnt moves to the next requester or to 0000 at that edge.
- Late requester: req=0100 while requester 1 holds a locked tenure. Requester 2 is granted at the edge where requester 1 releases. ptr becomes 2, and the next search starts at 3.

Source files
------------

// File: rtl/reg_share_arbiter_pkg.sv
// Shared types and defaults for the shared-register arbiter slice.
// Width helper keeps one-requester / one-cycle corner cases at 1 bit.
package reg_share_arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_DW       = 8;
  localparam int DEF_MAX_HOLD = 4;

  function automatic int width_of(input int n);
    if (n <= 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/reg_share_arbiter_rr_pick.sv
// Combinational round-robin picker: the asserted request closest to ptr
// (counting upward with wrap) wins.
module reg_share_arbiter_rr_pick
  import reg_share_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  localparam int PW   = width_of(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] win,
  output logic [PW-1:0]    win_idx,
  output logic             any_req
);

  int best_dist_s;
  int dist_s;

  // Pick the requester with the smallest wrapped distance from ptr.
  always_comb begin
    best_dist_s = N_REQ;
    dist_s      = 0;
    win_idx     = {PW{1'b0}};
    win         = {N_REQ{1'b0}};
    any_req     = |req;
    for (int i = 0; i < N_REQ; i++) begin
      dist_s = i - int'(ptr);
      if (dist_s < 0) begin
        dist_s = dist_s + N_REQ;
      end else begin
        dist_s = dist_s;
      end
      if (req[i] && (dist_s < best_dist_s)) begin
        best_dist_s = dist_s;
        win_idx     = PW'(i);
      end else begin
        best_dist_s = best_dist_s;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      win[i] = any_req && (win_idx == PW'(i));
    end
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin owner FSM for one shared DW-bit register; the owner writes on
// every cycle it keeps req high, and may lock the register for MAX_HOLD cycles.
module reg_share_arbiter
  import reg_share_arbiter_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int DW       = DEF_DW,
  parameter int MAX_HOLD = DEF_MAX_HOLD,
  localparam int PW      = width_of(N_REQ),
  localparam int HW      = width_of(MAX_HOLD + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ-1:0]    lock,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [PW-1:0]       owner_id,
  output logic                busy,
  output logic [DW-1:0]       q
);

  state_e           state_r;
  logic [PW-1:0]    ptr_r;
  logic [HW-1:0]    hold_cnt_r;

  logic             own_req_s;
  logic             own_lock_s;
  logic [DW-1:0]    own_data_s;
  logic             extend_s;
  logic [PW-1:0]    nxt_ptr_s;
  logic [PW-1:0]    pick_ptr_s;
  logic [N_REQ-1:0] win_s;
  logic [PW-1:0]    win_idx_s;
  logic             any_req_s;

  // Owner-side views, release pointer and the pointer the picker searches from.
  always_comb begin
    own_req_s  = 1'b0;
    own_lock_s = 1'b0;
    own_data_s = {DW{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_id == PW'(i)) begin
        own_req_s  = req[i];
        own_lock_s = lock[i];
        own_data_s = wdata[i*DW +: DW];
      end else begin
        own_req_s  = own_req_s;
      end
    end
    extend_s = own_req_s && own_lock_s && (hold_cnt_r < HW'(MAX_HOLD - 1));
    if (owner_id == PW'(N_REQ - 1)) begin
      nxt_ptr_s = {PW{1'b0}};
    end else begin
      nxt_ptr_s = owner_id + PW'(1);
    end
    // On release the search must already start past the releasing owner.
    if (state_r == OWN) begin
      pick_ptr_s = nxt_ptr_s;
    end else begin
      pick_ptr_s = ptr_r;
    end
  end

  reg_share_arbiter_rr_pick #(
    .N_REQ (N_REQ)
  ) u_pick (
    .req     (req),
    .ptr     (pick_ptr_s),
    .win     (win_s),
    .win_idx (win_idx_s),
    .any_req (any_req_s)
  );

  // Tenure FSM with registered grant outputs and the shared register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      ptr_r      <= {PW{1'b0}};
      hold_cnt_r <= {HW{1'b0}};
      gnt        <= {N_REQ{1'b0}};
      owner_id   <= {PW{1'b0}};
      busy       <= 1'b0;
      q          <= {DW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          hold_cnt_r <= {HW{1'b0}};
          if (any_req_s) begin
            state_r  <= OWN;
            gnt      <= win_s;
            owner_id <= win_idx_s;
            busy     <= 1'b1;
          end else begin
            gnt  <= {N_REQ{1'b0}};
            busy <= 1'b0;
          end
        end
        OWN: begin
          if (own_req_s) begin
            q <= own_data_s;
          end else begin
            q <= q;
          end
          if (extend_s) begin
            hold_cnt_r <= hold_cnt_r + HW'(1);
          end else begin
            ptr_r      <= nxt_ptr_s;
            hold_cnt_r <= {HW{1'b0}};
            if (any_req_s) begin
              gnt      <= win_s;
              owner_id <= win_idx_s;
            end else begin
              state_r <= IDLE;
              gnt     <= {N_REQ{1'b0}};
              busy    <= 1'b0;
            end
          end
        end
        default: begin
          state_r    <= IDLE;
          hold_cnt_r <= {HW{1'b0}};
          gnt        <= {N_REQ{1'b0}};
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed, table-driven bench for reg_share_arbiter (N_REQ=4, DW=8, MAX_HOLD=4).
module tb_reg_share_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = 4'b0000;
  logic [3:0]  lock = 4'b0000;
  logic [31:0] wdata = 32'h0;
  logic [3:0]  gnt;
  logic [1:0]  owner_id;
  logic        busy;
  logic [7:0]  q;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    bit          rst_before;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic        busy;
    logic [1:0]  owner;
    logic [7:0]  q;
  } vec_t;

  vec_t vq[$];

  reg_share_arbiter #(
    .N_REQ    (4),
    .DW       (8),
    .MAX_HOLD (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .lock     (lock),
    .wdata    (wdata),
    .gnt      (gnt),
    .owner_id (owner_id),
    .busy     (busy),
    .q        (q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = 4'b0000;
    lock = 4'b0000;
    #2;
    rst = 1'b0;
  endtask

  task automatic add(input string n, input bit rb, input logic [3:0] r, input logic [3:0] l,
                     input logic [31:0] wd, input logic [3:0] g, input logic b,
                     input logic [1:0] o, input logic [7:0] qq);
    vec_t v;
    v.name = n; v.rst_before = rb; v.req = r; v.lock = l; v.wdata = wd;
    v.gnt = g; v.busy = b; v.owner = o; v.q = qq;
    vq.push_back(v);
  endtask

  initial begin
    // Single requester, unlocked: regranted every cycle, one write per cycle.
    add("single1", 1'b1, 4'b0001, 4'b0000, 32'h000000A5, 4'b0001, 1'b1, 2'd0, 8'h00);
    add("single2", 1'b0, 4'b0001, 4'b0000, 32'h000000A5, 4'b0001, 1'b1, 2'd0, 8'hA5);
    add("single3", 1'b0, 4'b0001, 4'b0000, 32'h0000003C, 4'b0001, 1'b1, 2'd0, 8'h3C);
    add("single4", 1'b0, 4'b0000, 4'b0000, 32'h0000003C, 4'b0000, 1'b0, 2'd0, 8'h3C);
    // Full contention rotation with wrap.
    add("cont1", 1'b1, 4'b1111, 4'b0000, 32'h44332211, 4'b0001, 1'b1, 2'd0, 8'h00);
    add("cont2", 1'b0, 4'b1111, 4'b0000, 32'h44332211, 4'b0010, 1'b1, 2'd1, 8'h11);
    add("cont3", 1'b0, 4'b1111, 4'b0000, 32'h44332211, 4'b0100, 1'b1, 2'd2, 8'h22);
    add("cont4", 1'b0, 4'b1111, 4'b0000, 32'h44332211, 4'b1000, 1'b1, 2'd3, 8'h33);
    add("cont5", 1'b0, 4'b1111, 4'b0000, 32'h44332211, 4'b0001, 1'b1, 2'd0, 8'h44);
    add("cont6", 1'b0, 4'b1111, 4'b0000, 32'h44332211, 4'b0010, 1'b1, 2'd1, 8'h11);
    add("cont7", 1'b0, 4'b0000, 4'b0000, 32'h44332211, 4'b0000, 1'b0, 2'd0, 8'h11);
    // Lock bound: four cycles for requester 0, one for requester 1.
    add("lock1", 1'b1, 4'b0011, 4'b0001, 32'h0000B1A0, 4'b0001, 1'b1, 2'd0, 8'h00);
    add("lock2", 1'b0, 4'b0011, 4'b0001, 32'h0000B1A0, 4'b0001, 1'b1, 2'd0, 8'hA0);
    add("lock3", 1'b0, 4'b0011, 4'b0001, 32'h0000B1A0, 4'b0001, 1'b1, 2'd0, 8'hA0);
    add("lock4", 1'b0, 4'b0011, 4'b0001, 32'h0000B1A0, 4'b0001, 1'b1, 2'd0, 8'hA0);
    add("lock5", 1'b0, 4'b0011, 4'b0001, 32'h0000B1A0, 4'b0010, 1'b1, 2'd1, 8'hA0);
    add("lock6", 1'b0, 4'b0011, 4'b0001, 32'h0000B1A0, 4'b0001, 1'b1, 2'd0, 8'hB1);
    add("lock7", 1'b0, 4'b0011, 4'b0001, 32'h0000B1A0, 4'b0001, 1'b1, 2'd0, 8'hA0);
    // Owner drops req mid-lock: no write, grant hands over at the same edge.
    add("drop1", 1'b1, 4'b0001, 4'b0001, 32'h00000077, 4'b0001, 1'b1, 2'd0, 8'h00);
    add("drop2", 1'b0, 4'b0001, 4'b0001, 32'h00000077, 4'b0001, 1'b1, 2'd0, 8'h77);
    add("drop3", 1'b0, 4'b0100, 4'b0001, 32'h00000088, 4'b0100, 1'b1, 2'd2, 8'h77);
    add("drop4", 1'b0, 4'b0000, 4'b0001, 32'h00000088, 4'b0000, 1'b0, 2'd0, 8'h77);
    // Late requester during a locked tenure, then search resumes at 3.
    add("late1", 1'b1, 4'b0010, 4'b0010, 32'hE7C35A00, 4'b0010, 1'b1, 2'd1, 8'h00);
    add("late2", 1'b0, 4'b0010, 4'b0010, 32'hE7C35A00, 4'b0010, 1'b1, 2'd1, 8'h5A);
    add("late3", 1'b0, 4'b0110, 4'b0010, 32'hE7C35A00, 4'b0010, 1'b1, 2'd1, 8'h5A);
    add("late4", 1'b0, 4'b0110, 4'b0010, 32'hE7C35A00, 4'b0010, 1'b1, 2'd1, 8'h5A);
    add("late5", 1'b0, 4'b0110, 4'b0010, 32'hE7C35A00, 4'b0100, 1'b1, 2'd2, 8'h5A);
    add("late6", 1'b0, 4'b1110, 4'b0010, 32'hE7C35A00, 4'b1000, 1'b1, 2'd3, 8'hC3);
    add("late7", 1'b0, 4'b0000, 4'b0000, 32'hE7C35A00, 4'b0000, 1'b0, 2'd0, 8'hC3);

    #12;
    chk("rst_gnt", {28'h0, gnt}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_owner", {30'h0, owner_id}, 32'h0);
    chk("rst_q", {24'h0, q}, 32'h0);
    rst = 1'b0;

    foreach (vq[i]) begin
      if (vq[i].rst_before) begin
        do_reset();
      end
      req = vq[i].req;
      lock = vq[i].lock;
      wdata = vq[i].wdata;
      step();
      chk({vq[i].name, "_gnt"}, {28'h0, gnt}, {28'h0, vq[i].gnt});
      chk({vq[i].name, "_busy"}, {31'h0, busy}, {31'h0, vq[i].busy});
      chk({vq[i].name, "_q"}, {24'h0, q}, {24'h0, vq[i].q});
      if (vq[i].busy) begin
        chk({vq[i].name, "_owner"}, {30'h0, owner_id}, {30'h0, vq[i].owner});
      end
    end

    // Asynchronous reset in the middle of a locked tenure.
    do_reset();
    req = 4'b0001;
    lock = 4'b0001;
    wdata = 32'h000000AB;
    step();
    chk("arst_pre_gnt", {28'h0, gnt}, 32'h1);
    step();
    chk("arst_pre_q", {24'h0, q}, 32'hAB);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_gnt", {28'h0, gnt}, 32'h0);
    chk("arst_busy", {31'h0, busy}, 32'h0);
    chk("arst_q", {24'h0, q}, 32'h0);
    #1;
    rst = 1'b0;
    req = 4'b1001;
    lock = 4'b0000;
    wdata = 32'hCD0000AB;
    step();
    chk("arst_first_gnt", {28'h0, gnt}, 32'h1);
    chk("arst_first_q", {24'h0, q}, 32'h0);
    step();
    chk("arst_next_gnt", {28'h0, gnt}, 32'h8);
    chk("arst_next_q", {24'h0, q}, 32'hAB);
    step();
    chk("arst_wrap_gnt", {28'h0, gnt}, 32'h1);
    chk("arst_wrap_q", {24'h0, q}, 32'hCD);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
